// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream link carrying one opaque payload bundle between pipeline stages.
// Ports: valid, ready, data[W-1:0]; master drives valid/data, slave drives ready.
// The same link type serves both the upstream and downstream side of a stage.
interface pipe_stage_buf_if #(
    parameter int W = 144
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with optional 2-entry skid, flush and scratch side channel.
// Latency: 1 cycle from up accept to dn_data/dn_valid; scratch channel also 1 cycle.
// Backpressure: SKID=1 gives registered up.ready (= skid empty); SKID=0 gives combinational up.ready.
// Ports: clk, rst (async active-low), flush, stall, up (slave link), dn (master link),
//        temp_req/temp_i -> temp_ack/temp_o scratch capture, occ = number of held entries.
module pipe_stage_buf #(
    parameter int DATA_W = 144,
    parameter int TEMP_W = 64,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    pipe_stage_buf_if.slave   up,
    pipe_stage_buf_if.master  dn,
    input  logic              temp_req,
    input  logic [TEMP_W-1:0] temp_i,
    output logic              temp_ack,
    output logic [TEMP_W-1:0] temp_o,
    output logic [1:0]        occ
);

    logic              main_vld;
    logic [DATA_W-1:0] main_dat;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic              up_rdy;
    logic              up_fire;
    logic              dn_fire;

    // With the skid present, ready depends only on a flop, which breaks the
    // combinational ready path back through the pipeline.
    assign up_rdy  = (SKID != 0) ? ~skid_vld
                                 : (~main_vld | (dn.ready & ~stall));
    assign up_fire = up.valid & up_rdy;
    assign dn_fire = main_vld & dn.ready & ~stall;

    assign up.ready = up_rdy;
    assign dn.valid = main_vld;
    assign dn.data  = main_dat;
    assign occ      = {1'b0, main_vld} + {1'b0, skid_vld};

    // Entry storage. The skid can only be occupied while main is occupied, so
    // an empty main never needs to look at the skid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (!main_vld) begin
            if (up_fire) begin
                main_vld <= 1'b1;
                main_dat <= up.data;
            end
        end else if (dn_fire) begin
            if (skid_vld) begin
                // up_rdy is low while the skid is full, so no new payload arrives here.
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (up_fire) begin
                main_dat <= up.data;
            end else begin
                // dn_data keeps the last delivered value while empty.
                main_vld <= 1'b0;
            end
        end else if (up_fire && (SKID != 0)) begin
            skid_vld <= 1'b1;
            skid_dat <= up.data;
        end
    end

    // Scratch side channel for iterative units: it only captures while the
    // pipeline is stalled, and reads back zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            temp_ack <= 1'b0;
            temp_o   <= '0;
        end else if (flush || !stall) begin
            temp_ack <= 1'b0;
            temp_o   <= '0;
        end else begin
            temp_ack <= temp_req;
            temp_o   <= temp_req ? temp_i : '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic        flush0, stall0, treq0, tack0;
    logic [63:0] ti0, to0;
    logic [1:0]  occ0;
    pipe_stage_buf_if #(.W(144)) up0 ();
    pipe_stage_buf_if #(.W(144)) dn0 ();

    pipe_stage_buf #(.DATA_W(144), .TEMP_W(64), .SKID(1)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .stall(stall0),
        .up(up0.slave), .dn(dn0.master),
        .temp_req(treq0), .temp_i(ti0), .temp_ack(tack0), .temp_o(to0), .occ(occ0)
    );

    // SKID=0 instance
    logic        flush1, stall1, treq1, tack1;
    logic [63:0] ti1, to1;
    logic [1:0]  occ1;
    pipe_stage_buf_if #(.W(16)) up1 ();
    pipe_stage_buf_if #(.W(16)) dn1 ();

    pipe_stage_buf #(.DATA_W(16), .TEMP_W(64), .SKID(0)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .stall(stall1),
        .up(up1.slave), .dn(dn1.master),
        .temp_req(treq1), .temp_i(ti1), .temp_ack(tack1), .temp_o(to1), .occ(occ1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [143:0] DA = 144'hA1, DB = 144'hB2, DC = 144'hC3, DD = 144'hD4,
                             DE = 144'hE5, DF = 144'hF6, DG = 144'h17, DH = 144'h28,
                             DJ = 144'h39;
    localparam logic [63:0]  TV = 64'h1234_5678_9ABC_DEF0;

    initial begin
        logic [15:0] nxt;
        logic        exp_rdy;

        rst = 1'b0;
        flush0 = 0; stall0 = 0; treq0 = 0; ti0 = '0;
        up0.valid = 0; up0.data = '0; dn0.ready = 0;
        flush1 = 0; stall1 = 0; treq1 = 0; ti1 = '0;
        up1.valid = 0; up1.data = '0; dn1.ready = 0;

        // Reset state
        #3;
        check("rst_dn_valid", dn0.valid, 0);
        check("rst_dn_data",  dn0.data, 0);
        check("rst_occ",      occ0, 0);
        check("rst_temp_ack", tack0, 0);
        check("rst_temp_o",   to0, 0);
        #4 rst = 1'b1;
        tick();
        check("rst_up_ready", up0.ready, 1);

        // 1. Streaming A,B,C at full rate
        dn0.ready = 1; up0.valid = 1; up0.data = DA;
        tick();
        check("s1_A", dn0.data, DA); check("s1_A_vld", dn0.valid, 1); check("s1_A_occ", occ0, 1);
        up0.data = DB;
        tick();
        check("s1_B", dn0.data, DB); check("s1_B_occ", occ0, 1);
        up0.data = DC;
        tick();
        check("s1_C", dn0.data, DC); check("s1_C_occ", occ0, 1);
        up0.valid = 0;
        tick();
        check("s1_empty_vld", dn0.valid, 0); check("s1_empty_occ", occ0, 0);
        check("s1_keep_data", dn0.data, DC);

        // 2. Downstream backpressure fills the skid
        dn0.ready = 0; up0.valid = 1; up0.data = DA;
        tick();
        check("s2_A_main", dn0.data, DA); check("s2_occ1", occ0, 1); check("s2_rdy1", up0.ready, 1);
        up0.data = DB;
        tick();
        check("s2_occ2", occ0, 2); check("s2_rdy0", up0.ready, 0); check("s2_main_A", dn0.data, DA);
        up0.data = DC;
        tick();
        check("s2_hold_occ", occ0, 2); check("s2_hold_A", dn0.data, DA); check("s2_hold_rdy", up0.ready, 0);
        dn0.ready = 1;
        tick();
        check("s2_drain_B", dn0.data, DB); check("s2_drain_occ", occ0, 1); check("s2_drain_rdy", up0.ready, 1);
        tick();
        check("s2_drain_C", dn0.data, DC); check("s2_drain_C_occ", occ0, 1);
        up0.valid = 0;
        tick();
        check("s2_empty", occ0, 0); check("s2_empty_vld", dn0.valid, 0);

        // 3. Scratch channel
        stall0 = 1; treq0 = 1; ti0 = TV;
        tick();
        check("s3_ack", tack0, 1); check("s3_val", to0, TV);
        stall0 = 0;
        tick();
        check("s3_ack_clr", tack0, 0); check("s3_val_clr", to0, 0);
        treq0 = 0;

        // 4. Flush with both entries full overrides stall, up_fire and temp_req
        dn0.ready = 0; up0.valid = 1; up0.data = DD;
        tick();
        up0.data = DE;
        tick();
        check("s4_occ2", occ0, 2);
        flush0 = 1; stall0 = 1; treq0 = 1;
        tick();
        check("s4_occ", occ0, 0); check("s4_vld", dn0.valid, 0); check("s4_data", dn0.data, 0);
        check("s4_ack", tack0, 0); check("s4_temp_o", to0, 0); check("s4_rdy", up0.ready, 1);
        flush0 = 0; stall0 = 0; treq0 = 0; up0.valid = 0;
        tick();
        check("s4_stays_empty", occ0, 0);

        // 5. Asynchronous reset mid-cycle with occ=2
        up0.valid = 1; up0.data = DF;
        tick();
        up0.data = DG;
        tick();
        check("s5_occ2", occ0, 2);
        up0.valid = 0;
        #3 rst = 1'b0;
        #1;
        check("s5_async_vld", dn0.valid, 0); check("s5_async_occ", occ0, 0);
        check("s5_async_data", dn0.data, 0);
        #2 rst = 1'b1;
        dn0.ready = 1;
        tick();
        check("s5_post_vld_a", dn0.valid, 0);
        tick();
        check("s5_post_vld_b", dn0.valid, 0);
        up0.valid = 1; up0.data = DH;
        tick();
        check("s5_new_H", dn0.data, DH); check("s5_new_vld", dn0.valid, 1);

        // Stall freezes delivery but upstream still fills the skid
        stall0 = 1; up0.data = DJ;
        tick();
        check("st_occ2", occ0, 2); check("st_hold_H", dn0.data, DH);
        stall0 = 0; up0.valid = 0;
        tick();
        check("st_drain_J", dn0.data, DJ); check("st_drain_occ", occ0, 1);
        tick();
        check("st_empty", occ0, 0);

        // 6. SKID=0 with stall toggling every cycle (starting high)
        dn1.ready = 1; up1.valid = 1; nxt = 16'd1;
        for (int i = 0; i < 10; i++) begin
            stall1  = (i % 2 == 0);
            up1.data = nxt;
            exp_rdy = (i == 0) || (i % 2 == 1);
            #1;
            check($sformatf("s6_rdy_%0d", i), up1.ready, exp_rdy);
            check($sformatf("s6_occ_%0d", i), occ1, (i == 0) ? 0 : 1);
            if (i % 2 == 1)
                check($sformatf("s6_data_%0d", i), dn1.data, 16'((i + 1) / 2));
            if (exp_rdy) nxt = nxt + 16'd1;
            @(posedge clk);
            #1;
        end
        up1.valid = 0; stall1 = 0;
        tick();
        tick();
        check("s6_empty", occ1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
